// File: rtl/dec_pkg.sv
// Shared definitions for the parameterised sequencing decoder.
// Holds the controller state encoding and the meaning of the mode input.
package dec_pkg;

  // Controller states: IDLE parks the outputs, DECODE follows the
  // sel handshake, SCAN walks every index on its own.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Values carried on the mode input.
  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/param_seq_decoder_if.sv
// Bundle of handshake and result signals for param_seq_decoder.
//   en, mode      : block enable and DECODE/SCAN selection
//   sel_valid/sel : decode request and the index to decode
//   sel_ready     : decoder accepts sel this cycle
//   y, y_valid    : registered one-hot (or one-cold) word and its strobe
//   idx, wrap     : index currently shown on y, SCAN roll-over pulse
// master = request side, slave = the decoder itself.
interface param_seq_decoder_if #(
  parameter int SEL_W = 3
);
  logic                    en;
  logic                    mode;
  logic                    sel_valid;
  logic [SEL_W-1:0]        sel;
  logic                    sel_ready;
  logic [(2**SEL_W)-1:0]   y;
  logic                    y_valid;
  logic [SEL_W-1:0]        idx;
  logic                    wrap;

  modport master (
    output en, mode, sel_valid, sel,
    input  sel_ready, y, y_valid, idx, wrap
  );

  modport slave (
    input  en, mode, sel_valid, sel,
    output sel_ready, y, y_valid, idx, wrap
  );
endinterface

// File: rtl/onehot_dec.sv
// Purely combinational binary to one-hot decoder.
//   bin    : SEL_W-bit binary index
//   onehot : 2**SEL_W-bit word with only bit[bin] set
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      bin,
  output logic [(2**SEL_W)-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**SEL_W; gi++) begin : g_bit
      assign onehot[gi] = (bin == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/param_seq_decoder.sv
// Parameterised decoder with a select-driven mode and a self-sequencing
// scan mode. All results on y/y_valid/idx/wrap are registered; only
// sel_ready is combinational.
//   clk : system clock, everything changes on its rising edge
//   rst : synchronous active-high reset
//   bus : param_seq_decoder_if slave (en, mode, sel handshake, results)
// SEL_W selects the index width (1..6), ACTIVE_LOW inverts every bit of y.
module param_seq_decoder
  import dec_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  param_seq_decoder_if.slave bus
);

  localparam int               N          = 2**SEL_W;
  localparam logic [N-1:0]     Y_INACTIVE = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};
  localparam logic [SEL_W-1:0] IDX_MAX    = {SEL_W{1'b1}};

  state_t           state_reg, state_next;
  logic [N-1:0]     y_reg, y_next;
  logic [SEL_W-1:0] idx_reg, idx_next;
  logic             y_valid_reg, y_valid_next;
  logic             wrap_reg, wrap_next;

  logic             accept;
  logic             load_y;
  logic             clear_y;
  logic [N-1:0]     dec_onehot;

  // rst is folded in so a request is never acknowledged while the block
  // is being reset, whatever state the register happened to hold.
  assign bus.sel_ready = !rst && (state_reg == ST_DECODE) && bus.en &&
                         (bus.mode == MODE_DECODE);
  assign accept        = bus.sel_ready && bus.sel_valid;

  // Next state and next index. Any enabled state goes straight to the run
  // state chosen by mode, so IDLE->run and run->other-run share one path.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    y_valid_next = 1'b0;
    wrap_next    = 1'b0;
    load_y       = 1'b0;
    clear_y      = 1'b0;
    if (!bus.en) begin
      state_next = ST_IDLE;
      idx_next   = '0;
      clear_y    = 1'b1;
    end else if (bus.mode == MODE_SCAN) begin
      state_next   = ST_SCAN;
      load_y       = 1'b1;
      y_valid_next = 1'b1;
      if (state_reg != ST_SCAN) begin
        // Entering SCAN always restarts at index 0 with no wrap pulse.
        idx_next = '0;
      end else begin
        idx_next  = idx_reg + SEL_W'(1);
        wrap_next = (idx_reg == IDX_MAX);
      end
    end else begin
      state_next = ST_DECODE;
      if (accept) begin
        idx_next     = bus.sel;
        load_y       = 1'b1;
        y_valid_next = 1'b1;
      end
    end
  end

  // The single decoder looks at the index about to be registered, so y and
  // idx always describe the same position.
  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_onehot_dec (
    .bin    (idx_next),
    .onehot (dec_onehot)
  );

  // Polarity is applied here, on the way into the output register.
  always_comb begin
    y_next = y_reg;
    if (clear_y) begin
      y_next = Y_INACTIVE;
    end else if (load_y) begin
      y_next = ACTIVE_LOW ? ~dec_onehot : dec_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      y_reg       <= Y_INACTIVE;
      idx_reg     <= '0;
      y_valid_reg <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      y_reg       <= y_next;
      idx_reg     <= idx_next;
      y_valid_reg <= y_valid_next;
      wrap_reg    <= wrap_next;
    end
  end

  assign bus.y       = y_reg;
  assign bus.idx     = idx_reg;
  assign bus.y_valid = y_valid_reg;
  assign bus.wrap    = wrap_reg;

endmodule

// File: tb/tb_param_seq_decoder.sv
// Self-checking bench for param_seq_decoder (SEL_W=3). Two instances share
// one stimulus: an active-high one and an ACTIVE_LOW one. Expected values
// come from a behavioural model built on integer index arithmetic.
module tb_param_seq_decoder;

  localparam int SW = 3;
  localparam int N  = 8;
  localparam int M_IDLE = 0;
  localparam int M_DEC  = 1;
  localparam int M_SCAN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_seq_decoder_if #(.SEL_W(SW)) bus ();
  param_seq_decoder_if #(.SEL_W(SW)) bus_al ();

  assign bus_al.en        = bus.en;
  assign bus_al.mode      = bus.mode;
  assign bus_al.sel_valid = bus.sel_valid;
  assign bus_al.sel       = bus.sel;

  param_seq_decoder #(.SEL_W(SW), .ACTIVE_LOW(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  param_seq_decoder #(.SEL_W(SW), .ACTIVE_LOW(1'b1)) dut_al (
    .clk (clk),
    .rst (rst),
    .bus (bus_al.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model: which mode is running, which index is shown.
  int m_state = M_IDLE;
  int m_idx   = 0;
  bit m_shown = 1'b0;
  bit m_valid = 1'b0;
  bit m_wrap  = 1'b0;

  function automatic logic [N-1:0] exp_y();
    return m_shown ? N'(1 << m_idx) : '0;
  endfunction

  function automatic logic [N+SW+1:0] exp_obs();
    return {exp_y(), SW'(m_idx), m_valid, m_wrap};
  endfunction

  function automatic logic [N+SW+1:0] dut_obs();
    return {bus.y, bus.idx, bus.y_valid, bus.wrap};
  endfunction

  function automatic bit model_ready();
    return !rst && (m_state == M_DEC) && bus.en && !bus.mode;
  endfunction

  // Advance one clock: update the model from the inputs present at the
  // edge, then sample the DUT 1 time unit after the edge.
  task automatic tick();
    bit rdy;
    rdy = model_ready();
    if (rst || !bus.en) begin
      m_state = M_IDLE; m_idx = 0; m_shown = 0; m_valid = 0; m_wrap = 0;
    end else if (bus.mode) begin
      if (m_state != M_SCAN) begin
        m_idx = 0; m_wrap = 0;
      end else begin
        m_wrap = (m_idx == N - 1);
        m_idx  = (m_idx + 1) % N;
      end
      m_shown = 1; m_valid = 1; m_state = M_SCAN;
    end else begin
      m_wrap = 0;
      if (rdy && bus.sel_valid) begin
        m_idx = int'(bus.sel); m_shown = 1; m_valid = 1;
      end else begin
        m_valid = 0;
      end
      m_state = M_DEC;
    end
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d rst=%b en=%b mode=%b sv=%b sel=%0d -> y=%h idx=%0d v=%b w=%b y_al=%h",
             cyc, rst, bus.en, bus.mode, bus.sel_valid, bus.sel,
             bus.y, bus.idx, bus.y_valid, bus.wrap, bus_al.y);
  endtask

  task automatic test_reset();
    rst = 1; bus.en = 1; bus.mode = 0; bus.sel_valid = 1; bus.sel = 3'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.y, bus.idx, bus.y_valid, bus.wrap} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_outputs got y=%h idx=%0d v=%b w=%b need y=00 idx=0 v=0 w=0",
                 bus.y, bus.idx, bus.y_valid, bus.wrap);
      end
      checks++;
      if (bus.sel_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready got %b need 0", bus.sel_ready);
      end
      checks++;
      if (bus_al.y !== 8'hFF) begin
        errors++;
        $display("FAIL reset_al_y got %h need ff", bus_al.y);
      end
    end
    rst = 0;
    #1;
    checks++;
    if (bus.sel_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release got %b need 0", bus.sel_ready);
    end
    tick();
  endtask

  task automatic test_decode_sweep();
    bus.en = 1; bus.mode = 0; bus.sel_valid = 1;
    for (int s = 0; s < N; s++) begin
      bus.sel = SW'(s);
      #1;
      checks++;
      if (bus.sel_ready !== 1'b1) begin
        errors++;
        $display("FAIL sweep_ready sel=%0d got %b need 1", s, bus.sel_ready);
      end
      tick();
      checks++;
      if (bus.y !== 8'(1 << s) || bus.y_valid !== 1'b1 || bus.idx !== SW'(s)) begin
        errors++;
        $display("FAIL sweep_y sel=%0d got y=%h idx=%0d v=%b need y=%h idx=%0d v=1",
                 s, bus.y, bus.idx, bus.y_valid, 8'(1 << s), s);
      end
    end
    bus.sel_valid = 0;
    tick();
    checks++;
    if (dut_obs() !== exp_obs()) begin
      errors++;
      $display("FAIL sweep_hold got %h need %h", dut_obs(), exp_obs());
    end
  endtask

  task automatic test_scan17();
    int hits;
    hits = 0;
    bus.en = 1; bus.mode = 1; bus.sel_valid = 1;
    for (int c = 1; c <= 17; c++) begin
      bus.sel = SW'($urandom_range(0, N - 1));
      tick();
      if (bus.wrap === 1'b1) hits |= (1 << c);
      checks++;
      if (bus.idx !== SW'((c - 1) % N) || $countones(bus.y) != 1 || bus.y_valid !== 1'b1
          || dut_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL scan17 c=%0d got idx=%0d y=%h v=%b need idx=%0d obs=%h",
                 c, bus.idx, bus.y, bus.y_valid, (c - 1) % N, exp_obs());
      end
    end
    checks++;
    if (hits != ((1 << 9) | (1 << 17))) begin
      errors++;
      $display("FAIL scan17_wrap_cycles got %h need %h", hits, (1 << 9) | (1 << 17));
    end
  endtask

  task automatic test_scan_pause_and_reset();
    bus.en = 0; bus.sel_valid = 0;
    tick();
    bus.en = 1; bus.mode = 1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.idx !== 3'd4) begin
      errors++;
      $display("FAIL pause_reach4 got idx=%0d need 4", bus.idx);
    end
    bus.en = 0;
    tick();
    checks++;
    if ({bus.y, bus.idx, bus.y_valid, bus.wrap} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pause_idle got y=%h idx=%0d v=%b w=%b need 00/0/0/0",
               bus.y, bus.idx, bus.y_valid, bus.wrap);
    end
    bus.en = 1;
    tick();
    checks++;
    if ({bus.y, bus.idx, bus.y_valid, bus.wrap} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pause_restart got y=%h idx=%0d v=%b w=%b need 01/0/1/0",
               bus.y, bus.idx, bus.y_valid, bus.wrap);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.idx !== 3'd6) begin
      errors++;
      $display("FAIL rst_scan_reach6 got idx=%0d need 6", bus.idx);
    end
    rst = 1; bus.sel_valid = 1;
    tick();
    checks++;
    if ({bus.y, bus.idx, bus.y_valid, bus.wrap} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_scan got y=%h idx=%0d v=%b w=%b need 00/0/0/0",
               bus.y, bus.idx, bus.y_valid, bus.wrap);
    end
    rst = 0; bus.mode = 0;
    #1;
    checks++;
    if (bus.sel_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_scan_idle got ready=%b need 0", bus.sel_ready);
    end
    tick();
  endtask

  task automatic test_active_low();
    bus.en = 0; bus.sel_valid = 0;
    tick();
    checks++;
    if (bus_al.y !== 8'hFF) begin
      errors++;
      $display("FAIL al_idle got %h need ff", bus_al.y);
    end
    bus.en = 1; bus.mode = 0;
    tick();
    bus.sel_valid = 1; bus.sel = 3'd5;
    tick();
    checks++;
    if (bus_al.y !== 8'hDF || bus_al.idx !== 3'd5) begin
      errors++;
      $display("FAIL al_decode5 got y=%h idx=%0d need y=df idx=5", bus_al.y, bus_al.idx);
    end
  endtask

  task automatic test_random();
    bit rdy;
    for (int i = 0; i < 300; i++) begin
      rst           = ($urandom_range(0, 39) == 0);
      bus.en        = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) bus.mode = ~bus.mode;
      bus.sel_valid = $urandom_range(0, 1);
      bus.sel       = SW'($urandom_range(0, N - 1));
      #1;
      rdy = model_ready();
      checks++;
      if (bus.sel_ready !== rdy) begin
        errors++;
        $display("FAIL rand_ready i=%0d got %b need %b", i, bus.sel_ready, rdy);
      end
      tick();
      checks++;
      if (dut_obs() !== exp_obs() || bus_al.y !== ~exp_y() || $countones(bus.y) > 1) begin
        errors++;
        $display("FAIL rand_obs i=%0d got %h al=%h need %h al=%h",
                 i, dut_obs(), bus_al.y, exp_obs(), ~exp_y());
      end
    end
    rst = 0;
  endtask

  initial begin
    bus.en = 0; bus.mode = 0; bus.sel_valid = 0; bus.sel = '0;
    test_reset();
    test_decode_sweep();
    test_scan17();
    test_scan_pause_and_reset();
    test_active_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
